// File: rtl/seq_divider_p.sv
// Multi-cycle restoring divider, signed/unsigned, one quotient bit per cycle.
// Define SEQ_DIV_EARLY_OUT_EN to skip the iterations when |divisor| > |dividend| or divisor == 0.
module seq_divider_p #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             sgn,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dmag_q, dmag_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;
  logic dbz_q, dbz_d;
  logic early_q, early_d;
  logic busy_q, busy_d;
  logic ready_q, ready_d;
  logic dbzo_q, dbzo_d;

  logic             accept;
  logic             dvd_neg;
  logic             dvs_neg;
  logic             early_hit;
  logic [WIDTH-1:0] amag;
  logic [WIDTH-1:0] bmag;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;

  assign accept  = run && (state_q == S_IDLE || state_q == S_DONE);
  assign dvd_neg = sgn & dividend[WIDTH-1];
  assign dvs_neg = sgn & divisor[WIDTH-1];
  assign amag    = dvd_neg ? -dividend : dividend;
  assign bmag    = dvs_neg ? -divisor : divisor;

  // Top bit of the WIDTH+1 difference is the borrow of the trial subtract
  assign trial = {rem_q, quo_q[WIDTH-1]};
  assign diff  = trial - {1'b0, dmag_q};

`ifdef SEQ_DIV_EARLY_OUT_EN
  assign early_hit = (divisor == '0) || (bmag > amag);
`else
  assign early_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (run) begin
          state_d = early_hit ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        if (cnt_q == LAST) begin
          state_d = S_FIX;
        end
      end
      S_FIX: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dmag_d  = dmag_q;
    dvd_d   = dvd_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dbz_d   = dbz_q;
    early_d = early_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    dbzo_d  = dbzo_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    if (accept) begin
      dvd_d   = dividend;
      dmag_d  = bmag;
      quo_d   = amag;
      rem_d   = '0;
      cnt_d   = '0;
      qneg_d  = dvd_neg ^ dvs_neg;
      rneg_d  = dvd_neg;
      dbz_d   = (divisor == '0);
      early_d = early_hit;
      busy_d  = 1'b1;
      ready_d = 1'b0;
    end else if (state_q == S_CALC) begin
      rem_d = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
      cnt_d = cnt_q + 1'b1;
    end else if (state_q == S_FIX) begin
      if (dbz_q) begin
        quot_d = '1;
      end else if (early_q) begin
        quot_d = '0;
      end else begin
        quot_d = qneg_q ? -quo_q : quo_q;
      end
      if (dbz_q || early_q) begin
        remo_d = dvd_q;
      end else begin
        remo_d = rneg_q ? -rem_q : rem_q;
      end
      dbzo_d  = dbz_q;
      busy_d  = 1'b0;
      ready_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dmag_q  <= '0;
      dvd_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dbz_q   <= 1'b0;
      early_q <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      dbzo_q  <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dmag_q  <= dmag_d;
      dvd_q   <= dvd_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dbz_q   <= dbz_d;
      early_q <= early_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      dbzo_q  <= dbzo_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
    end
  end

  assign busy      = busy_q;
  assign ready     = ready_q;
  assign dbz       = dbzo_q;
  assign quotient  = quot_q;
  assign remainder = remo_q;

endmodule

// File: tb/tb_seq_divider_p.sv
// Bench for seq_divider_p: latency/result model checked every cycle,
// plus literal cases and a WIDTH=8 instance.
module tb_seq_divider_p;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        sgn = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, ready, dbz;
  logic [31:0] quotient, remainder;

  logic        run8 = 1'b0;
  logic        sgn8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        busy8, ready8, dbz8;
  logic [7:0]  q8, r8;

  int tests = 0;
  int fails = 0;

  seq_divider_p #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .sgn(sgn),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .ready(ready),
    .quotient(quotient), .remainder(remainder), .dbz(dbz)
  );

  seq_divider_p #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .run(run8), .sgn(sgn8),
    .dividend(a8), .divisor(b8),
    .busy(busy8), .ready(ready8),
    .quotient(q8), .remainder(r8), .dbz(dbz8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic longint sval(input logic [31:0] v, input logic s);
    return s ? longint'($signed(v)) : longint'(v);
  endfunction

  function automatic longint mag(input logic [31:0] v, input logic s);
    longint x;
    x = sval(v, s);
    return (x < 0) ? -x : x;
  endfunction

  task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                         input logic s, output logic [31:0] q,
                         output logic [31:0] r, output logic z);
    if (b == 0) begin
      q = '1; r = a; z = 1'b1;
    end else begin
      q = 32'(sval(a, s) / sval(b, s));
      r = 32'(sval(a, s) % sval(b, s));
      z = 1'b0;
    end
  endtask

  function automatic int lat32(input logic [31:0] a, input logic [31:0] b,
                               input logic s);
`ifdef SEQ_DIV_EARLY_OUT_EN
    if (b == 0 || mag(b, s) > mag(a, s)) return 1;
`endif
    return 33;
  endfunction

  // Behavioural model: an accepted op finishes a fixed latency later
  logic        m_busy = 0, m_ready = 0, m_dbz = 0, p_dbz = 0;
  logic [31:0] m_q = 0, m_r = 0, p_q = 0, p_r = 0;
  int          m_left = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_ready = 0; m_dbz = 0;
      m_q = 0; m_r = 0; m_left = 0;
    end else if (!m_busy && run) begin
      ref_div(dividend, divisor, sgn, p_q, p_r, p_dbz);
      m_busy = 1; m_ready = 0;
      m_left = lat32(dividend, divisor, sgn);
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 0; m_ready = 1;
        m_q = p_q; m_r = p_r; m_dbz = p_dbz;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_busy));
    chk("ready", 32'(ready), 32'(m_ready));
    chk("quotient", quotient, m_q);
    chk("remainder", remainder, m_r);
    chk("dbz", 32'(dbz), 32'(m_dbz));
  end

  logic acc_ready;
  logic acc_busy;

  task automatic op(input logic [31:0] a, input logic [31:0] b,
                    input logic s, output int n);
    @(negedge clk); #1;
    run = 1; dividend = a; divisor = b; sgn = s;
    @(posedge clk); #1;
    run = 0;
    acc_ready = ready;
    acc_busy = busy;
    n = 1;
    @(posedge clk); #1;
    while (!ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("op_done", 32'(ready), 32'd1);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic s, output int n);
    @(negedge clk); #1;
    run8 = 1; a8 = a; b8 = b; sgn8 = s;
    @(posedge clk); #1;
    run8 = 0;
    n = 0;
    while (!ready8 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("op8_done", 32'(ready8), 32'd1);
  endtask

  task automatic ref8(input logic [7:0] a, input logic [7:0] b,
                      input logic s, output logic [7:0] q,
                      output logic [7:0] r);
    int sa, sb;
    sa = s ? int'($signed(a)) : int'(a);
    sb = s ? int'($signed(b)) : int'(b);
    if (b == 0) begin
      q = 8'hFF; r = a;
    end else begin
      q = 8'(sa / sb); r = 8'(sa % sb);
    end
  endtask

  function automatic logic [31:0] rnd_op();
    unique case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(0, 3));
      default: return $urandom >> $urandom_range(0, 31);
    endcase
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int lat;
    logic [31:0] a, b;
    logic [7:0] e8q, e8r, x8, y8;
    logic s;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_q", quotient, 32'd0);
    #10 rst_n = 1;

    op(32'd100, 32'd7, 1'b0, n);
    chk("u100_7_acc_busy", 32'(acc_busy), 32'd1);
    chk("u100_7_lat", n, 33);
    chk("u100_7_q", quotient, 32'd14);
    chk("u100_7_r", remainder, 32'd2);
    chk("u100_7_dbz", 32'(dbz), 32'd0);

    op(-32'sd100, 32'd7, 1'b1, n);
    chk("sm100_7_q", quotient, 32'hFFFF_FFF2);
    chk("sm100_7_r", remainder, 32'hFFFF_FFFE);

    op(32'd100, -32'sd7, 1'b1, n);
    chk("s100_m7_q", quotient, 32'hFFFF_FFF2);
    chk("s100_m7_r", remainder, 32'd2);

    op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, n);
    chk("ovf_q", quotient, 32'h8000_0000);
    chk("ovf_r", remainder, 32'd0);
    chk("ovf_dbz", 32'(dbz), 32'd0);

    op(32'd55, 32'd0, 1'b1, n);
`ifdef SEQ_DIV_EARLY_OUT_EN
    chk("dbz_lat", n, 1);
`else
    chk("dbz_lat", n, 33);
`endif
    chk("dbz_q", quotient, 32'hFFFF_FFFF);
    chk("dbz_r", remainder, 32'd55);
    chk("dbz_flag", 32'(dbz), 32'd1);

    // run held high and operands scrambled while busy
    @(negedge clk); #1;
    run = 1; dividend = 32'd1000; divisor = 32'd9; sgn = 0;
    @(posedge clk); #1;
    n = 0;
    while (!ready && n < 100) begin
      dividend = $urandom; divisor = $urandom; sgn = 1'($urandom);
      @(posedge clk); #1;
      n++;
    end
    run = 0;
    chk("hold_lat", n, 33);
    chk("hold_q", quotient, 32'd111);
    chk("hold_r", remainder, 32'd1);

    op(32'd50, 32'd5, 1'b0, n);
    chk("redo_ready_drop", 32'(acc_ready), 32'd0);
    chk("redo_lat", n, 33);
    chk("redo_q", quotient, 32'd10);

    // abort mid-calculation
    @(negedge clk); #1;
    run = 1; dividend = 32'd12345; divisor = 32'd7; sgn = 0;
    @(posedge clk); #1;
    run = 0;
    repeat (9) @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(ready), 32'd0);
    chk("abort_q", quotient, 32'd0);
    chk("abort_r", remainder, 32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1;
    op(32'hFFFF_FFFF, 32'h10, 1'b0, n);
    chk("post_lat", n, 33);
    chk("post_q", quotient, 32'h0FFF_FFFF);
    chk("post_r", remainder, 32'hF);

    for (int i = 0; i < 150; i++) begin
      a = rnd_op();
      b = rnd_op();
      s = 1'($urandom);
      lat = lat32(a, b, s);
      op(a, b, s, n);
      chk("rand_lat", n, lat);
    end

    op8(8'd200, 8'd3, 1'b0, n);
    chk("w8_lat", n, 9);
    chk("w8_q", 32'(q8), 32'd66);
    chk("w8_r", 32'(r8), 32'd2);
    op8(8'd3, 8'd200, 1'b0, n);
`ifdef SEQ_DIV_EARLY_OUT_EN
    chk("w8_early_lat", n, 1);
`else
    chk("w8_early_lat", n, 9);
`endif
    chk("w8_early_q", 32'(q8), 32'd0);
    chk("w8_early_r", 32'(r8), 32'd3);
    for (int i = 0; i < 40; i++) begin
      x8 = 8'($urandom);
      y8 = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom >> $urandom_range(0, 7));
      s = 1'($urandom);
      ref8(x8, y8, s, e8q, e8r);
      op8(x8, y8, s, n);
      chk("w8_rand_q", 32'(q8), 32'(e8q));
      chk("w8_rand_r", 32'(r8), 32'(e8r));
      chk("w8_rand_dbz", 32'(dbz8), 32'(y8 == 0));
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_divider_p.md
Name: seq_divider_p

Overview:
- Parametrised multi-cycle restoring divider; successor to the fixed 32-bit unsigned divider in the ALU datapath.
- Computes quotient and remainder of WIDTH-bit operands, one quotient bit per cycle.
- Adds selectable signed/unsigned mode, a divide-by-zero flag, a busy/ready handshake and asynchronous active-low reset.
- Sits beside the ALU and multiplier and is driven by the same run/ready control style.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- run  input  1  start request; sampled on rising edge.
- sgn  input  1  1 = two's-complement signed divide, 0 = unsigned; captured with operands.
- dividend  input  WIDTH  dividend, captured when run is accepted.
- divisor  input  WIDTH  divisor, captured when run is accepted.
- busy  output  1  high while a division is in progress.
- ready  output  1  result valid; held until the next accepted run.
- quotient  output  WIDTH  quotient result.
- remainder  output  WIDTH  remainder result.
- dbz  output  1  divide-by-zero flag; valid with ready.

Behaviour:
- Reset (rst_n low, async): state=IDLE; busy, ready, dbz = 0; quotient, remainder, counter and internal registers = 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE + run=1 at edge E: operation is accepted.
  - Capture operands and sgn.
  - Form unsigned magnitudes (negate operands that are negative when sgn=1).
  - Record sign of quotient = sign(dividend) XOR sign(divisor); sign of remainder = sign(dividend).
  - Record dbz = (divisor==0). Clear ready. Go to CALC with counter=0.
  - busy=1 from edge E until the FIX->DONE edge.
- CALC: one restoring step per edge.
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor magnitude from the upper half using a WIDTH+1-bit subtract.
  - If there is no borrow, keep the difference and set quo LSB=1; otherwise restore and set LSB=0.
  - After WIDTH steps (edges E+1..E+WIDTH) go to FIX.
- FIX (edge E+WIDTH+1): apply signs and overrides, register outputs, set ready=1, busy=0, go to DONE.
  - Negate the quotient magnitude if the quotient sign is negative.
  - Negate the remainder magnitude if the remainder sign is negative.
- Latency: ready observed high after edge E+WIDTH+1, i.e. WIDTH+1 cycles after acceptance.
- Divide by zero: quotient = all ones (-1 signed); remainder = original dividend unchanged; dbz=1. The full latency still applies.
- Signed overflow (MIN / -1): quotient = MIN, remainder = 0, dbz=0. This falls out of the magnitude path; no special case is added.
- run while busy (CALC/FIX): ignored; operand and sgn changes are also ignored.
- run while in DONE: a new operation is accepted; ready drops on that edge. The previous quotient/remainder stay on the outputs until the next FIX.
- Outputs are stable and ready stays high in DONE indefinitely while run=0.
- rst_n low mid-operation: immediate abort; all outputs return to reset values; no partial result is ever presented.

Optional Feature:
- Macro: SEQ_DIV_EARLY_OUT_EN.
- Defined: at acceptance, if dbz=1 or |divisor| > |dividend|, skip CALC and go directly to FIX.
  - Result: quotient = 0 (or -1 on dbz), remainder = dividend.
  - Latency in this case: ready after edge E+1.
  - All other cases keep the normal latency.
- Undefined: every operation takes WIDTH+1 cycles; no comparator is built.

Test Plan:
- WIDTH=32, sgn=0, 100/7 -> quotient=14, remainder=2, dbz=0; ready exactly 33 cycles after the accepting edge; busy high for the 33 cycles in between.
- WIDTH=32, sgn=1, -100/7 -> quotient=-14 (0xFFFFFFF2), remainder=-2 (0xFFFFFFFE); and 100/-7 -> quotient=-14, remainder=2.
- sgn=1, 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, dbz=0. Then 55/0 -> quotient=0xFFFFFFFF, remainder=55, dbz=1.
- Hold run=1 and change operands during CALC -> those changes are ignored and the result matches the first operands. Then assert run in DONE -> ready drops next edge and the new result is ready 33 cycles later.
- Pull rst_n low at cycle 10 of CALC -> outputs go to 0 asynchronously and state returns to IDLE. A new run then completes correctly: 0xFFFFFFFF/0x10 unsigned -> quotient=0x0FFFFFFF, remainder=0xF.
- WIDTH=8, sgn=0, 200/3 -> quotient=66, remainder=2, ready after 9 cycles. With SEQ_DIV_EARLY_OUT_EN defined, 3/200 -> quotient=0, remainder=3, ready after 1 cycle.
